// File: rtl/c2s_pkt_gen.sv
`default_nettype none
// ============================================================================
// c2s_pkt_gen : framed AXI-Stream packet generator for the DMA C2S path.
// Optional stats counters under `C2S_PKT_GEN_STATS_EN.  Rev 1.0
// ============================================================================
module c2s_pkt_gen #(
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    m_axi_lite_aclk,
  input  logic                    m_axi_lite_aresetn,
  input  logic                    cfg_enable,
  input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
  input  logic [31:0]             cfg_pkt_count,
  input  logic                    c2s_tready,
  output logic                    c2s_tvalid,
  output logic [DATA_WIDTH-1:0]   c2s_tdata,
  output logic                    c2s_tlast,
  output logic [DATA_WIDTH/8-1:0] c2s_tkeep,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_beats
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [31:0]   tkeep_q, tkeep_d;
  logic [31:0]   bcnt_q, bcnt_d;
  logic [31:0]   seq_q, seq_d;
  logic [15:0]   idx_q, idx_d;
  logic [15:0]   last_idx_q, last_idx_d;
  logic [31:0]   last_keep_q, last_keep_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          busy_q, done_q;

  logic [LEN_WIDTH:0] w_len_ext;
  logic [15:0]        w_cfg_last_idx;
  logic [31:0]        w_cfg_keep;
  logic [15:0]        w_next_idx;
  logic               w_hs;

  // Beats per packet is ceil(len/32); the stored value is the index of the last beat.
  assign w_len_ext      = {1'b0, cfg_pkt_len} + (LEN_WIDTH+1)'(31);
  assign w_cfg_last_idx = {4'b0, w_len_ext[LEN_WIDTH:5]} - 16'd1;
  assign w_cfg_keep     = (cfg_pkt_len[4:0] == 5'd0) ? 32'hFFFF_FFFF
                                                     : (32'h1 << cfg_pkt_len[4:0]) - 32'h1;
  assign w_next_idx     = idx_q + 16'd1;
  assign w_hs           = tvalid_q & c2s_tready;

  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tkeep_d     = tkeep_q;
    bcnt_d      = bcnt_q;
    seq_d       = seq_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    last_keep_d = last_keep_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        tvalid_d = 1'b0;
        if (cfg_enable) begin
          if (cfg_pkt_len != '0) begin
            state_d     = S_SEND;
            last_idx_d  = w_cfg_last_idx;
            last_keep_d = w_cfg_keep;
            cnt_d       = cfg_pkt_count;
            idx_d       = 16'd0;
            seq_d       = 32'd0;
            tvalid_d    = 1'b1;
            tlast_d     = (w_cfg_last_idx == 16'd0);
            tkeep_d     = (w_cfg_last_idx == 16'd0) ? w_cfg_keep : 32'hFFFF_FFFF;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (w_hs) begin
          bcnt_d = bcnt_q + 32'd1;
          if (tlast_q) begin
            if ((cnt_q != 32'd0) && (seq_q + 32'd1 == cnt_q)) begin
              state_d  = S_DONE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tkeep_d  = 32'd0;
            end else if (!cfg_enable) begin
              state_d  = S_IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tkeep_d  = 32'd0;
            end else begin
              seq_d   = seq_q + 32'd1;
              idx_d   = 16'd0;
              tlast_d = (last_idx_q == 16'd0);
              tkeep_d = (last_idx_q == 16'd0) ? last_keep_q : 32'hFFFF_FFFF;
            end
          end else begin
            idx_d   = w_next_idx;
            tlast_d = (w_next_idx == last_idx_q);
            tkeep_d = (w_next_idx == last_idx_q) ? last_keep_q : 32'hFFFF_FFFF;
          end
        end
      end
      S_DONE: begin
        tvalid_d = 1'b0;
        if (!cfg_enable) state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge m_axi_lite_aclk or negedge m_axi_lite_aresetn) begin
    if (!m_axi_lite_aresetn) begin
      state_q     <= S_IDLE;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tkeep_q     <= 32'd0;
      bcnt_q      <= 32'd0;
      seq_q       <= 32'd0;
      idx_q       <= 16'd0;
      last_idx_q  <= 16'd0;
      last_keep_q <= 32'd0;
      cnt_q       <= 32'd0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tkeep_q     <= tkeep_d;
      bcnt_q      <= bcnt_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      last_keep_q <= last_keep_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      busy_q      <= (state_d == S_SEND);
      done_q      <= (state_d == S_DONE);
    end
  end

`ifdef C2S_PKT_GEN_STATS_EN
  logic [31:0] stat_pkts_q, stat_beats_q;

  always_ff @(posedge m_axi_lite_aclk or negedge m_axi_lite_aresetn) begin
    if (!m_axi_lite_aresetn) begin
      stat_pkts_q  <= 32'd0;
      stat_beats_q <= 32'd0;
    end else if (w_hs) begin
      stat_beats_q <= stat_beats_q + 32'd1;
      if (tlast_q) stat_pkts_q <= stat_pkts_q + 32'd1;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_beats = stat_beats_q;
`else
  assign stat_pkts  = 32'd0;
  assign stat_beats = 32'd0;
`endif

  // Payload fields are held directly in registers so tdata needs no extra stage.
  assign c2s_tdata  = {{(DATA_WIDTH-80){1'b0}}, idx_q, seq_q, bcnt_q};
  assign c2s_tvalid = tvalid_q;
  assign c2s_tlast  = tlast_q;
  assign c2s_tkeep  = tkeep_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = err_q;

endmodule
`default_nettype wire

// File: doc/c2s_pkt_gen.md
# c2s_pkt_gen

Packet generator that drives the card-to-system (C2S) AXI-Stream input of the DMA engine. It produces framed, length-controlled packets with a self-describing payload: free-running beat counter, packet sequence number and beat index. Combined with tlast and tkeep, this lets host software verify DMA framing, ordering and byte counts. It sits in the application layer alongside the GPIO register block and takes the place of the unframed counter source on the C2S path.

## Interface
Parameters:
- `DATA_WIDTH`, 256: stream data width in bits; fixed at 256 for this DMA.
- `LEN_WIDTH`, 16: width of the packet-length configuration in bytes.

Ports:
- `m_axi_lite_aclk` in, 1: single clock for the whole block.
- `m_axi_lite_aresetn` in, 1: reset; asynchronous, active-low.
- `cfg_enable` in, 1: run request, level-sensitive.
- `cfg_pkt_len` in, 16: packet length in bytes; 0 is illegal.
- `cfg_pkt_count` in, 32: packets per run; 0 means continuous.
- `c2s_tready` in, 1: DMA accepts a beat.
- `c2s_tvalid` out, 1: beat valid.
- `c2s_tdata` out, 256: beat payload.
- `c2s_tlast` out, 1: last beat of packet.
- `c2s_tkeep` out, 32: byte enables.
- `busy` out, 1: high in SEND.
- `done` out, 1: high in DONE.
- `cfg_err` out, 1: sticky; set when a start is attempted with `cfg_pkt_len`==0.
- `stat_pkts` out, 32: packets accepted (tlast handshakes).
- `stat_beats` out, 32: beats accepted.

## Operation
- States: IDLE, SEND, DONE.
- **IDLE → SEND:** when `cfg_enable`=1 and `cfg_pkt_len`≠0. On entry, latch length and count; clear packet sequence and beat index.
- **IDLE with length 0:** `cfg_enable`=1 with `cfg_pkt_len`=0 sets `cfg_err` and the block stays in IDLE. `cfg_err` clears only on reset.
- **Beats per packet:** ceil(len/32).
  - Non-last beats: tkeep=32'hFFFFFFFF.
  - Last beat: r=len[4:0]; tkeep=all ones if r=0, else (1<<r)-1.
- **Payload per beat:**
  - [31:0]: beat counter. Starts at 0 after reset, +1 per accepted beat, wraps at 2^32, and is never cleared between runs.
  - [63:32]: packet sequence number within the run, starting at 0.
  - [79:64]: beat index within the packet.
  - [255:80]: zero.
- **AXI-Stream rules:** once tvalid=1, tdata/tlast/tkeep hold stable until tready=1. tvalid never drops without a handshake.
- **Packet boundaries:** on a tlast handshake, the sequence number increments and the beat index resets to 0. The next packet starts on the very next cycle, with no gap.
- **SEND → DONE:** on the tlast handshake of packet number `cfg_pkt_count` (count≠0).
- **SEND → IDLE:** `cfg_enable` deasserted mid-packet has no immediate effect; the current packet completes, then the FSM goes to IDLE. Packets are never truncated.
- **DONE → IDLE:** when `cfg_enable`=0. DONE holds tvalid=0.
- **Config changes during SEND:** ignored; latched values govern the run.
- **Continuous mode:** the sequence number wraps at 2^32.

## Timing
- **Reset values:** tvalid=0, tdata=0, tlast=0, tkeep=0, busy=0, done=0, cfg_err=0, stat_pkts=0, stat_beats=0. State is IDLE; all counters 0.
- **Output registers:** all outputs are registered; no combinational path from tready to any output.
- **Start latency:** `cfg_enable` sampled high in IDLE gives tvalid=1 on the next cycle.
- **Throughput:** one beat per cycle while tready=1.
- **tvalid after run end:** tvalid drops the cycle after the final tlast handshake.
- **Done timing:** `done` rises the same cycle the state becomes DONE.
- **Reset mid-packet:** outputs return to their reset values immediately. No tlast is emitted for the partial packet.

## Configuration
- Macro `C2S_PKT_GEN_STATS_EN`.
- **Defined:** `stat_pkts`/`stat_beats` count accepted packets and beats, wrap at 2^32, and clear only on reset.
- **Undefined:** the counters are not built and both outputs are tied to 0. All other behaviour is identical.

## Test plan
- **Single packet:** len=100, count=1, tready=1 → 4 beats; tkeep FFFFFFFF ×3 then 0000000F; tlast on beat 3; beat index 0..3; done=1; stat_pkts=1, stat_beats=4.
- **Aligned and sub-beat lengths:** len=64, count=3 → 6 beats, tlast on every 2nd, last tkeep FFFFFFFF, seq 0,1,2. Then len=1 → 1 beat, tlast=1, tkeep=00000001.
- **Backpressure:** random tready at 50% with len=200 → tdata/tkeep/tlast stable while tvalid & !tready; beat counter strictly consecutive across handshakes.
- **Disable mid-packet:** count=0, len=320; drop cfg_enable on beat 4 → beats 5..9 still sent, tlast on beat 9, then IDLE with tvalid=0.
- **Illegal length:** cfg_pkt_len=0, cfg_enable=1 → no tvalid, cfg_err=1, busy=0.
- **Reset mid-run:** assert aresetn low during beat 2 → all outputs 0 asynchronously. After release, a restart has beat counter 0 and seq 0.
